// File: rtl/bus_pkg.sv
// bus_pkg: shared AHB-Lite encodings, hole map and alignment helper.
package bus_pkg;
  typedef enum logic [1:0] {TR_IDLE = 2'b00, TR_BUSY = 2'b01, TR_NONSEQ = 2'b10, TR_SEQ = 2'b11} transfer_kind;
  typedef enum logic [2:0] {SZ_BYTE = 3'd0, SZ_HALF = 3'd1, SZ_WORD = 3'd2} transfer_size;
  typedef enum logic [2:0] {BURST_SINGLE = 3'd0, BURST_INCR = 3'd1} transfer_burst;
  typedef enum logic {RESP_OKAY = 1'b0, RESP_ERROR = 1'b1} transfer_response;
  typedef struct packed {
    logic cacheable;
    logic bufferable;
    logic privileged;
    logic data;
  } transfer_protection;
  // Bit i set routes region i to the internal default slave instead of slave i.
  localparam logic [31:0] HOLE_MASK = 32'h0;
  // Size code 3 is not a legal request and is rejected like a misaligned one.
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lsb);
    return size == 2'd1 ? lsb[0] : size == 2'd2 ? |lsb : size == 2'd3;
  endfunction
endpackage

// File: rtl/ahb_addr_decoder.sv
// ahb_addr_decoder: maps a byte address onto the slave region map.
//   addr_i  address to decode
//   hole_o  region is served by the default slave
//   idx_o   region index
//   sel_o   one-hot HSEL, all-zero for holes
module ahb_addr_decoder import bus_pkg::*; #(
  parameter int NSLV = 4,
  parameter logic [0:NSLV-2][31:0] MAP = {32'h0000_1000, 32'h0001_0000, 32'h4000_0000},
  parameter logic [NSLV-1:0] HOLES = '0,
  localparam int LW = $clog2(NSLV)
) (
  input  logic [31:0]     addr_i,
  output logic            hole_o,
  output logic [LW-1:0]   idx_o,
  output logic [NSLV-1:0] sel_o
);
  for (genvar g = 0; g < NSLV - 2; g++) begin : g_chk
    if (MAP[g] >= MAP[g+1]) begin : g_bad
      $error("ahb_addr_decoder: MAP is not strictly ascending");
    end
  end
  // Region index is the number of upper bounds at or below the address.
  always_comb begin
    idx_o = '0;
    for (int i = 0; i < NSLV - 1; i++)
      if (addr_i >= MAP[i]) idx_o = LW'(i + 1);
    hole_o = HOLES[idx_o];
    sel_o = hole_o ? '0 : NSLV'(1) << idx_o;
  end
endmodule

// File: rtl/ahb_lite_master_ctrl.sv
// ahb_lite_master_ctrl: single-transfer AHB-Lite master and slave interconnect.
//   clk, rst (async active-low)
//   m_*      core request/response port (start/ready handshake)
//   h*       AHB-Lite address/data phase outputs, hready broadcast
//   *_s      packed per-slave HRDATA/HREADYOUT/HRESP
module ahb_lite_master_ctrl import bus_pkg::*; #(
  parameter int NSLV = 4,
  parameter logic [0:NSLV-2][31:0] MAP = {32'h0000_1000, 32'h0001_0000, 32'h4000_0000},
  parameter logic [NSLV-1:0] HOLES = HOLE_MASK[NSLV-1:0],
  parameter int TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             m_start,
  input  logic             m_write,
  input  logic [31:0]      m_addr,
  input  logic [1:0]       m_size,
  input  logic [31:0]      m_wdata,
  output logic [31:0]      m_rdata,
  output logic             m_ready,
  output logic             m_resp,
  output logic [NSLV-1:0]  hsel,
  output logic [31:0]      haddr,
  output logic             hwrite,
  output logic [2:0]       hsize,
  output logic [1:0]       htrans,
  output logic [31:0]      hwdata,
  output logic             hready,
  input  logic [NSLV*32-1:0] hrdata_s,
  input  logic [NSLV-1:0]  hreadyout_s,
  input  logic [NSLV-1:0]  hresp_s
);
  localparam int LW = $clog2(NSLV);
  localparam int CW = $clog2(TIMEOUT + 2);
  typedef enum logic [2:0] {S_IDLE, S_ADDR, S_DATA, S_ERR1, S_ERR2} state_t;
  state_t state_q, state_d;
  logic [31:0] addr_q, wdata_q, rdata_q, rdata_d;
  logic [1:0] size_q;
  logic write_q, ready_q, ready_d, resp_q, resp_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic dec_hole;
  logic [LW-1:0] dec_idx;
  logic [NSLV-1:0] dec_sel;
  logic [NSLV-1:0][31:0] rdata_arr;
  // The registered address stays stable for the whole transfer, so its decode acts as the data-phase select.
  ahb_addr_decoder #(.NSLV(NSLV), .MAP(MAP), .HOLES(HOLES)) u_dec (
    .addr_i(addr_q),
    .hole_o(dec_hole),
    .idx_o (dec_idx),
    .sel_o (dec_sel)
  );
  assign rdata_arr = hrdata_s;
  assign haddr = addr_q;
  assign hwrite = write_q;
  assign hsize = {1'b0, size_q};
  assign hwdata = size_q == 2'd0 ? {4{wdata_q[7:0]}} : size_q == 2'd1 ? {2{wdata_q[15:0]}} : wdata_q;
  assign m_ready = ready_q;
  assign m_resp = resp_q;
  assign m_rdata = rdata_q;
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    ready_d = 1'b0;
    resp_d = RESP_OKAY;
    rdata_d = rdata_q;
    hready = 1'b1;
    htrans = TR_IDLE;
    hsel = '0;
    case (state_q)
      S_IDLE:
        if (m_start && !ready_q) begin
          if (misaligned(m_size, m_addr[1:0])) begin
            ready_d = 1'b1;
            resp_d = RESP_ERROR;
          end else state_d = S_ADDR;
        end
      S_ADDR: begin
        htrans = TR_NONSEQ;
        hsel = dec_sel;
        cnt_d = '0;
        state_d = dec_hole ? S_ERR1 : S_DATA;
      end
      S_DATA: begin
        hready = hreadyout_s[dec_idx];
        if (hready) begin
          ready_d = 1'b1;
          resp_d = hresp_s[dec_idx];
          rdata_d = hresp_s[dec_idx] ? rdata_q : rdata_arr[dec_idx];
          state_d = S_IDLE;
        end else if (hresp_s[dec_idx]) state_d = S_ERR2;
      end
      S_ERR1: begin
        hready = 1'b0;
        state_d = S_ERR2;
      end
      S_ERR2: begin
        hready = dec_hole | hreadyout_s[dec_idx];
        if (hready) begin
          ready_d = 1'b1;
          resp_d = RESP_ERROR;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // Wait cycles of a real slave are counted; hitting the limit forces an ERROR completion.
    if ((state_q == S_DATA || state_q == S_ERR2) && !hready) begin
      cnt_d = cnt_q == '1 ? cnt_q : cnt_q + 1'b1;
      if (TIMEOUT != 0 && int'(cnt_q) + 1 == TIMEOUT) begin
        ready_d = 1'b1;
        resp_d = RESP_ERROR;
        state_d = S_IDLE;
      end
    end
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state_q <= S_IDLE;
      addr_q <= '0;
      wdata_q <= '0;
      size_q <= '0;
      write_q <= 1'b0;
      cnt_q <= '0;
      ready_q <= 1'b0;
      resp_q <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      ready_q <= ready_d;
      resp_q <= resp_d;
      rdata_q <= rdata_d;
      if (state_q == S_IDLE && state_d == S_ADDR) begin
        addr_q <= m_addr;
        wdata_q <= m_wdata;
        size_q <= m_size;
        write_q <= m_write;
      end
    end
endmodule
